// File: rtl/gated_counter_bank.sv
// gated_counter_bank: a bank of gated rising-edge counters. When a channel's
// gate closes, its count and tag are latched as one pending 64-bit result.
// A round-robin arbiter then drains pending results into the downstream FIFO,
// at most one word per cycle, and holds off while fifo_full is high.
// Optional feature: define COUNTER_SATURATE_EN to make the counters stop at
// all-ones. When it is undefined, the counters wrap.
module gated_counter_bank #(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned COUNT_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] count_in,
    input  logic [NUM_CHANNELS-1:0] count_enable,
    input  logic [7:0]              counter_id,
    input  logic                    fifo_full,
    output logic [63:0]             fifo_data,
    output logic                    fifo_data_ready
);

    localparam int unsigned PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] in_q;
    logic [NUM_CHANNELS-1:0] en_q;
    logic [NUM_CHANNELS-1:0] pending;
    logic [NUM_CHANNELS-1:0] lost;
    logic [NUM_CHANNELS-1:0] rise;
    logic [NUM_CHANNELS-1:0] close;
    logic [NUM_CHANNELS-1:0] grant;
    logic [COUNT_WIDTH-1:0]  cnt    [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]  res    [NUM_CHANNELS];
    logic [7:0]              res_id [NUM_CHANNELS];
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        sel;
    logic                    sel_valid;
    logic                    emit;
    logic [39:0]             sel_res;

    // Edge and gate-close detection against the previous-cycle samples.
    always_comb begin
        rise  = count_in & ~in_q;
        close = ~count_enable & en_q;
    end

    // Round-robin search: pick the first pending channel at or after ptr,
    // wrapping around the end of the bank.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_valid = 1'b0;
        sel       = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            idx = (32'(ptr) + i) % NUM_CHANNELS;
            if (!sel_valid && pending[idx[PTR_W-1:0]]) begin
                sel_valid = 1'b1;
                sel       = idx[PTR_W-1:0];
            end
        end
    end

    // One-hot grant to the channel whose result is being emitted this edge.
    always_comb begin
        emit  = sel_valid & ~fifo_full;
        grant = '0;
        if (emit) begin
            grant[sel] = 1'b1;
        end
        sel_res = 40'(res[sel]);
    end

    // Per-channel counting, result capture, and pending/lost bookkeeping.
    // A close that lands on the same edge as its own channel's emit still
    // loads the new result: the old word leaves and pending stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q    <= '1;
            en_q    <= '0;
            pending <= '0;
            lost    <= '0;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                cnt[ch]    <= '0;
                res[ch]    <= '0;
                res_id[ch] <= '0;
            end
        end else begin
            in_q <= count_in;
            en_q <= count_enable;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (grant[ch]) begin
                    pending[ch] <= 1'b0;
                    lost[ch]    <= 1'b0;
                end
                if (close[ch]) begin
                    cnt[ch] <= '0;
                    if (!pending[ch] || grant[ch]) begin
                        res[ch]     <= cnt[ch];
                        res_id[ch]  <= counter_id;
                        pending[ch] <= 1'b1;
                    end else begin
                        lost[ch] <= 1'b1;
                    end
                end else if (rise[ch] && count_enable[ch]) begin
`ifdef COUNTER_SATURATE_EN
                    if (cnt[ch] != '1) begin
                        cnt[ch] <= cnt[ch] + 1'b1;
                    end
`else
                    cnt[ch] <= cnt[ch] + 1'b1;
`endif
                end
            end
        end
    end

    // Output word register, write strobe, and round-robin pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr             <= '0;
            fifo_data       <= '0;
            fifo_data_ready <= 1'b0;
        end else begin
            fifo_data_ready <= emit;
            if (emit) begin
                fifo_data <= {(lost[sel] ? 8'h81 : 8'h01), 8'(sel), res_id[sel], sel_res};
                if (32'(sel) == NUM_CHANNELS - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= sel + 1'b1;
                end
            end
        end
    end

endmodule
